// File: rtl/ahb_arbiter_pkg.sv
// ahb_arbiter_pkg: TiniSOC system-bus encodings shared by the AHB arbiter.
// The `define block is the shared bus header. The package mirrors it as typed constants.
// Optional build macro consumed by ahb_arbiter: ARB_ROUND_ROBIN_EN.
`ifndef TINISOC_BUS_DEFS
`define TINISOC_BUS_DEFS
`define TRN_IDLE    2'b00
`define TRN_BUSY    2'b01
`define TRN_NONSEQ  2'b10
`define TRN_SEQ     2'b11
`define BST_SINGLE  3'b000
`define BST_INCR    3'b001
`define BST_WRAP4   3'b010
`define BST_INCR4   3'b011
`define BST_WRAP8   3'b100
`define BST_INCR8   3'b101
`define BST_WRAP16  3'b110
`define BST_INCR16  3'b111
`define MST_1       2'd1
`define MST_2       2'd2
`define MST_DEFAULT `MST_1
`endif

package ahb_arbiter_pkg;

  localparam int unsigned TRANS_W = 2;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned MST_W   = 2;
  localparam int unsigned CNT_W   = 4;

  localparam logic [TRANS_W-1:0] TRN_IDLE   = `TRN_IDLE;
  localparam logic [TRANS_W-1:0] TRN_BUSY   = `TRN_BUSY;
  localparam logic [TRANS_W-1:0] TRN_NONSEQ = `TRN_NONSEQ;
  localparam logic [TRANS_W-1:0] TRN_SEQ    = `TRN_SEQ;

  localparam logic [BURST_W-1:0] BST_SINGLE = `BST_SINGLE;
  localparam logic [BURST_W-1:0] BST_INCR   = `BST_INCR;
  localparam logic [BURST_W-1:0] BST_WRAP4  = `BST_WRAP4;
  localparam logic [BURST_W-1:0] BST_INCR4  = `BST_INCR4;
  localparam logic [BURST_W-1:0] BST_WRAP8  = `BST_WRAP8;
  localparam logic [BURST_W-1:0] BST_INCR8  = `BST_INCR8;
  localparam logic [BURST_W-1:0] BST_WRAP16 = `BST_WRAP16;
  localparam logic [BURST_W-1:0] BST_INCR16 = `BST_INCR16;

  localparam logic [MST_W-1:0] MST_1       = `MST_1;
  localparam logic [MST_W-1:0] MST_2       = `MST_2;
  localparam logic [MST_W-1:0] MST_DEFAULT = `MST_DEFAULT;

  // Remaining SEQ beats after the NONSEQ of a burst; 0 for SINGLE and open-ended INCR
  function automatic logic [CNT_W-1:0] burst_beats_m1(input logic [BURST_W-1:0] hburst);
    case (hburst)
      BST_WRAP4,  BST_INCR4:  return CNT_W'(3);
      BST_WRAP8,  BST_INCR8:  return CNT_W'(7);
      BST_WRAP16, BST_INCR16: return CNT_W'(15);
      BST_SINGLE, BST_INCR:   return CNT_W'(0);
      default:                return CNT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_counter.sv
// ahb_burst_counter: tracks remaining beats of the current fixed-length burst so the
// arbiter only hands the bus over between bursts. Also flags an open-ended INCR burst.
module ahb_burst_counter
  import ahb_arbiter_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [TRANS_W-1:0] HTRANS,
  input  logic [BURST_W-1:0] HBURST,
  input  logic               HREADY,
  output logic               window_open,
  output logic               incr_active
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             incr_nxt;

  // Next beat count from the transfer accepted on this edge
  always_comb begin
    cnt_nxt  = cnt_q;
    incr_nxt = incr_active;
    if (HREADY) begin
      case (HTRANS)
        TRN_NONSEQ: begin
          cnt_nxt  = burst_beats_m1(HBURST);
          incr_nxt = (HBURST == BST_INCR);
        end
        TRN_SEQ: begin
          if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
        end
        TRN_IDLE: begin
          // also cancels a burst abandoned after an ERROR response
          cnt_nxt  = '0;
          incr_nxt = 1'b0;
        end
        TRN_BUSY: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Count register; window flag registered alongside it
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q       <= '0;
      window_open <= 1'b1;
      incr_active <= 1'b0;
    end else begin
      cnt_q       <= cnt_nxt;
      window_open <= (cnt_nxt == '0);
      incr_active <= incr_nxt;
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: two-master AHB arbiter for the TiniSOC system bus. Parks on master 1.
// Build macro ARB_ROUND_ROBIN_EN: round-robin on contention instead of M1 > M2 priority.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HBUSREQ_M1,
  input  logic               HBUSREQ_M2,
  input  logic               HLOCK_M1,
  input  logic               HLOCK_M2,
  input  logic [TRANS_W-1:0] HTRANS,
  input  logic [BURST_W-1:0] HBURST,
  input  logic               HREADY,
  output logic               HGRANT_M1,
  output logic               HGRANT_M2,
  output logic [MST_W-1:0]   HMASTER,
  output logic [MST_W-1:0]   HMASTER_D,
  output logic               HMASTLOCK
);

  logic             window_open;
  logic             incr_active;
  logic [MST_W-1:0] gnt_id;
  logic [MST_W-1:0] gnt_nxt;
  logic             gnt_lock;
  logic             owner_req;
  logic             arb_open;
  logic [MST_W-1:0] contend_win;

  ahb_burst_counter u_burst_counter (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HTRANS      (HTRANS),
    .HBURST      (HBURST),
    .HREADY      (HREADY),
    .window_open (window_open),
    .incr_active (incr_active)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [MST_W-1:0] rr_last;
  logic             gnt_req;

  // Request of the granted master, for the round-robin pointer
  always_comb begin
    gnt_req = HGRANT_M2 ? HBUSREQ_M2 : HBUSREQ_M1;
  end

  // Pointer follows ownership moves to a requesting master; parking leaves it alone
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rr_last <= MST_1;
    end else if (HREADY && (gnt_id != HMASTER) && gnt_req) begin
      rr_last <= gnt_id;
    end
  end

  // Contention winner: the master not most recently given ownership
  always_comb begin
    contend_win = (rr_last == MST_1) ? MST_2 : MST_1;
  end
`else
  // Contention winner: fixed priority M1 over M2
  always_comb begin
    contend_win = MST_1;
  end
`endif

  // Handover window and next-grant selection
  always_comb begin
    gnt_id    = HGRANT_M2 ? MST_2 : MST_1;
    owner_req = (HMASTER == MST_2) ? HBUSREQ_M2 : HBUSREQ_M1;
    gnt_lock  = HGRANT_M2 ? (HLOCK_M2 & HBUSREQ_M2) : (HLOCK_M1 & HBUSREQ_M1);
    arb_open  = window_open && !HMASTLOCK && !(incr_active && owner_req);
    gnt_nxt   = gnt_id;
    if (arb_open) begin
      case ({HBUSREQ_M1, HBUSREQ_M2})
        2'b10:   gnt_nxt = MST_1;
        2'b01:   gnt_nxt = MST_2;
        2'b11:   gnt_nxt = contend_win;
        default: gnt_nxt = MST_DEFAULT;
      endcase
    end
  end

  // Grant, address/data owner and lock registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HGRANT_M1 <= 1'b1;
      HGRANT_M2 <= 1'b0;
      HMASTER   <= MST_DEFAULT;
      HMASTER_D <= MST_DEFAULT;
      HMASTLOCK <= 1'b0;
    end else begin
      HGRANT_M1 <= (gnt_nxt != MST_2);
      HGRANT_M2 <= (gnt_nxt == MST_2);
      if (HREADY) begin
        HMASTER   <= gnt_id;
        HMASTER_D <= HMASTER;
        HMASTLOCK <= gnt_lock;
      end
    end
  end

endmodule
